// File: rtl/vdp_vram_arbiter.sv
// -----------------------------------------------------------------------------
// vdp_vram_arbiter
//
// Shares the single SDRAM VRAM port between three requesters: screen fetch,
// CPU VRAM access and the VDP command engine. One transaction is in flight at
// a time. Byte accesses become 32-bit word accesses with a lane write mask.
// Read data goes back only to the requester that owns the transaction.
//
// Handshake semantics (all request ports and the dram port):
//   A requester raises *_valid with stable fields and holds it until *_ready.
//   *_ready is a one-cycle pulse in the cycle the SDRAM controller accepts
//   (dram_valid & dram_ready). The requester drops valid the following cycle.
//   Read data returns later as a one-cycle *_rdata_en pulse. *_rdata holds its
//   last value between pulses.
//
// Ports
//   clk, reset                 system clock, synchronous active-high reset
//   screen_address/valid       screen word read request (address [1:0] unused)
//   screen_ready               accept pulse
//   screen_rdata/_en           32-bit read word and its valid pulse
//   cpu_address/valid/write/wdata     CPU byte request
//   cpu_ready, cpu_rdata/_en          accept pulse, read byte + valid pulse
//   command_address/valid/write/wdata command engine byte request
//   command_ready, command_rdata/_en  accept pulse, read byte + valid pulse
//   dram_address/valid/write   request to SDRAM controller
//   dram_wdata, dram_wdata_mask       replicated write byte, 1 = lane kept
//   dram_ready                 controller accepted the request
//   dram_rdata, dram_rdata_en  read word from controller and its valid pulse
//   debug_state                current FSM state (0 IDLE, 1 ISSUE, 2 WAIT_RDATA)
// -----------------------------------------------------------------------------
module vdp_vram_arbiter #(
  parameter int CMD_STARVE_LIMIT = 4,
  parameter int RDATA_TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [16:0] screen_address,
  input  logic        screen_valid,
  output logic        screen_ready,
  output logic [31:0] screen_rdata,
  output logic        screen_rdata_en,
  input  logic [16:0] cpu_address,
  input  logic        cpu_valid,
  input  logic        cpu_write,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ready,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_rdata_en,
  input  logic [16:0] command_address,
  input  logic        command_valid,
  input  logic        command_write,
  input  logic [7:0]  command_wdata,
  output logic        command_ready,
  output logic [7:0]  command_rdata,
  output logic        command_rdata_en,
  output logic [16:0] dram_address,
  output logic        dram_valid,
  output logic        dram_write,
  output logic [31:0] dram_wdata,
  output logic [3:0]  dram_wdata_mask,
  input  logic        dram_ready,
  input  logic [31:0] dram_rdata,
  input  logic        dram_rdata_en,
  output logic [1:0]  debug_state
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ISSUE      = 2'd1,
    WAIT_RDATA = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE    = 2'd0,
    OWN_SCREEN  = 2'd1,
    OWN_CPU     = 2'd2,
    OWN_COMMAND = 2'd3
  } owner_t;

  localparam int SW = $clog2(CMD_STARVE_LIMIT + 1);
  localparam int TW = $clog2(RDATA_TIMEOUT + 1);

  state_t        state;
  owner_t        owner;
  logic [16:0]   addr_q;
  logic          write_q;
  logic [7:0]    wdata_q;
  logic [SW-1:0] starve_count;
  logic [TW-1:0] timeout_count;

  logic          cmd_starved;
  logic          grant_screen;
  logic          grant_cpu;
  logic          grant_command;
  logic          accept;
  logic          timeout_hit;
  logic          deliver;
  logic [31:0]   return_word;
  logic [7:0]    return_byte;

  assign cmd_starved = (starve_count == SW'(CMD_STARVE_LIMIT));

  // Screen always wins. Command normally loses to CPU, except once the CPU
  // has been granted CMD_STARVE_LIMIT times in a row while command waited.
  always_comb begin
    grant_screen  = 1'b0;
    grant_cpu     = 1'b0;
    grant_command = 1'b0;
    if (state == IDLE) begin
      if (screen_valid) begin
        grant_screen = 1'b1;
      end else if (command_valid && (cmd_starved || !cpu_valid)) begin
        grant_command = 1'b1;
      end else if (cpu_valid) begin
        grant_cpu = 1'b1;
      end
    end
  end

  assign accept = (state == ISSUE) && dram_ready;

  // dram side is driven straight from the latched request, so requester
  // field changes after the grant never reach the controller.
  assign dram_valid      = (state == ISSUE);
  assign dram_write      = (state == ISSUE) && write_q;
  assign dram_address    = addr_q;
  assign dram_wdata      = {4{wdata_q}};
  assign dram_wdata_mask = write_q ? ~(4'b0001 << addr_q[1:0]) : 4'b0000;

  assign screen_ready  = accept && (owner == OWN_SCREEN);
  assign cpu_ready     = accept && (owner == OWN_CPU);
  assign command_ready = accept && (owner == OWN_COMMAND);

  // A read that never returns is completed with all-ones data so the owner
  // is not left waiting forever.
  assign timeout_hit = (timeout_count == TW'(RDATA_TIMEOUT - 1));
  assign deliver     = (state == WAIT_RDATA) && (dram_rdata_en || timeout_hit);
  assign return_word = dram_rdata_en ? dram_rdata : 32'hFFFF_FFFF;
  assign return_byte = return_word[{addr_q[1:0], 3'b000} +: 8];

  assign debug_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      owner            <= OWN_NONE;
      addr_q           <= '0;
      write_q          <= 1'b0;
      wdata_q          <= '0;
      starve_count     <= '0;
      timeout_count    <= '0;
      screen_rdata     <= '0;
      screen_rdata_en  <= 1'b0;
      cpu_rdata        <= '0;
      cpu_rdata_en     <= 1'b0;
      command_rdata    <= '0;
      command_rdata_en <= 1'b0;
    end else begin
      screen_rdata_en  <= 1'b0;
      cpu_rdata_en     <= 1'b0;
      command_rdata_en <= 1'b0;

      // Starvation only accumulates while command keeps asking.
      if (!command_valid || grant_command) begin
        starve_count <= '0;
      end else if (grant_cpu && !cmd_starved) begin
        starve_count <= starve_count + SW'(1);
      end

      case (state)
        IDLE: begin
          if (grant_screen) begin
            owner   <= OWN_SCREEN;
            addr_q  <= screen_address;
            write_q <= 1'b0;
            wdata_q <= '0;
            state   <= ISSUE;
          end else if (grant_command) begin
            owner   <= OWN_COMMAND;
            addr_q  <= command_address;
            write_q <= command_write;
            wdata_q <= command_wdata;
            state   <= ISSUE;
          end else if (grant_cpu) begin
            owner   <= OWN_CPU;
            addr_q  <= cpu_address;
            write_q <= cpu_write;
            wdata_q <= cpu_wdata;
            state   <= ISSUE;
          end
        end

        ISSUE: begin
          if (dram_ready) begin
            timeout_count <= '0;
            if (write_q) begin
              state <= IDLE;
              owner <= OWN_NONE;
            end else begin
              state <= WAIT_RDATA;
            end
          end
        end

        WAIT_RDATA: begin
          if (deliver) begin
            case (owner)
              OWN_SCREEN: begin
                screen_rdata    <= return_word;
                screen_rdata_en <= 1'b1;
              end
              OWN_CPU: begin
                cpu_rdata    <= return_byte;
                cpu_rdata_en <= 1'b1;
              end
              OWN_COMMAND: begin
                command_rdata    <= return_byte;
                command_rdata_en <= 1'b1;
              end
              default: begin
              end
            endcase
            state <= IDLE;
            owner <= OWN_NONE;
          end else begin
            timeout_count <= timeout_count + TW'(1);
          end
        end

        default: begin
          state <= IDLE;
          owner <= OWN_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vdp_vram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vdp_vram_arbiter
//
// Drives the three requesters against a small SDRAM controller model with
// random accept/return latency. Expected dram issues and expected read
// returns are queued in grant order and compared as the DUT produces them.
// -----------------------------------------------------------------------------
module tb_vdp_vram_arbiter;

  localparam int RDATA_TIMEOUT = 255;
  localparam logic [1:0] OWN_SCREEN = 2'd1;
  localparam logic [1:0] OWN_CPU    = 2'd2;
  localparam logic [1:0] OWN_CMD    = 2'd3;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  logic [16:0] screen_address;
  logic        screen_valid;
  logic        screen_ready;
  logic [31:0] screen_rdata;
  logic        screen_rdata_en;
  logic [16:0] cpu_address;
  logic        cpu_valid;
  logic        cpu_write;
  logic [7:0]  cpu_wdata;
  logic        cpu_ready;
  logic [7:0]  cpu_rdata;
  logic        cpu_rdata_en;
  logic [16:0] command_address;
  logic        command_valid;
  logic        command_write;
  logic [7:0]  command_wdata;
  logic        command_ready;
  logic [7:0]  command_rdata;
  logic        command_rdata_en;
  logic [16:0] dram_address;
  logic        dram_valid;
  logic        dram_write;
  logic [31:0] dram_wdata;
  logic [3:0]  dram_wdata_mask;
  logic        dram_ready;
  logic [31:0] dram_rdata;
  logic        dram_rdata_en;
  logic [1:0]  debug_state;

  vdp_vram_arbiter #(
    .CMD_STARVE_LIMIT(4),
    .RDATA_TIMEOUT(RDATA_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .screen_address(screen_address), .screen_valid(screen_valid),
    .screen_ready(screen_ready), .screen_rdata(screen_rdata),
    .screen_rdata_en(screen_rdata_en),
    .cpu_address(cpu_address), .cpu_valid(cpu_valid), .cpu_write(cpu_write),
    .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .cpu_rdata_en(cpu_rdata_en),
    .command_address(command_address), .command_valid(command_valid),
    .command_write(command_write), .command_wdata(command_wdata),
    .command_ready(command_ready), .command_rdata(command_rdata),
    .command_rdata_en(command_rdata_en),
    .dram_address(dram_address), .dram_valid(dram_valid),
    .dram_write(dram_write), .dram_wdata(dram_wdata),
    .dram_wdata_mask(dram_wdata_mask), .dram_ready(dram_ready),
    .dram_rdata(dram_rdata), .dram_rdata_en(dram_rdata_en),
    .debug_state(debug_state)
  );

  // ---------------------------------------------------------------- checking
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // {owner[1:0], write, addr[16:0], wdata[31:0], mask[3:0]}
  logic [55:0] iss_q[$];
  // {timeout, owner[1:0], data[31:0]}
  logic [34:0] exp_q[$];

  // Word content the controller model returns, keyed by word address.
  function automatic logic [31:0] model_word(input logic [16:0] a);
    logic [14:0] k;
    k = a[16:2];
    return 32'h1122_3344 ^ {k[7:0], 1'b0, k[14:8], k[7:0], 8'h00};
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] own);
    case (own)
      OWN_SCREEN: return 3'b100;
      OWN_CPU:    return 3'b010;
      OWN_CMD:    return 3'b001;
      default:    return 3'b000;
    endcase
  endfunction

  task automatic push_txn(input logic [1:0] own, input logic wr, input logic [16:0] a,
                          input logic [7:0] d, input bit rd_expected, input bit tmo);
    logic [31:0] w;
    logic [3:0]  m;
    logic [31:0] word;
    w = wr ? {d, d, d, d} : 32'h0;
    case (a[1:0])
      2'd0:    m = 4'b1110;
      2'd1:    m = 4'b1101;
      2'd2:    m = 4'b1011;
      default: m = 4'b0111;
    endcase
    if (!wr) m = 4'b0000;
    iss_q.push_back({own, wr, a, w, m});
    if (!wr && rd_expected) begin
      word = tmo ? 32'hFFFF_FFFF : model_word(a);
      if (own != OWN_SCREEN) word = {24'h0, 8'(word >> {a[1:0], 3'b000})};
      exp_q.push_back({tmo, own, word});
    end
  endtask

  // ---------------------------------------------------------------- sdram model
  bit          no_resp = 1'b0;
  bit          inject_dre = 1'b0;
  bit          rd_pending = 1'b0;
  int          rd_delay = 0;
  logic [31:0] rd_word = '0;

  initial begin
    dram_ready    = 1'b0;
    dram_rdata_en = 1'b0;
    dram_rdata    = '0;
    forever begin
      @(posedge clk);
      #1;
      dram_ready    = 1'b0;
      dram_rdata_en = 1'b0;
      if (inject_dre) begin
        dram_rdata_en = 1'b1;
        dram_rdata    = 32'hDEAD_BEEF;
        inject_dre    = 1'b0;
      end
      if (rd_pending) begin
        if (rd_delay == 0) begin
          rd_pending = 1'b0;
          if (!no_resp) begin
            dram_rdata_en = 1'b1;
            dram_rdata    = rd_word;
          end
        end else begin
          rd_delay--;
        end
      end
      if (dram_valid && $urandom_range(0, 2) != 0) begin
        dram_ready = 1'b1;
        if (!dram_write) begin
          rd_pending = 1'b1;
          rd_delay   = $urandom_range(0, 3);
          rd_word    = model_word(dram_address);
        end
      end
    end
  end

  // ---------------------------------------------------------------- monitor
  int en_count = 0;
  int acc_cyc = 0;
  int last_dre_cyc = 0;

  initial begin
    logic [55:0] irec;
    logic [34:0] erec;
    logic [2:0]  rdy;
    logic [2:0]  en;
    logic [1:0]  e_own;
    logic [16:0] e_addr;
    forever begin
      @(negedge clk);
      rdy = {screen_ready, cpu_ready, command_ready};
      en  = {screen_rdata_en, cpu_rdata_en, command_rdata_en};
      if (dram_rdata_en) last_dre_cyc = cyc;
      if (dram_valid && dram_ready) begin
        acc_cyc = cyc;
        if (iss_q.size() == 0) begin
          check("unexp_issue", 64'(1), 64'(0));
        end else begin
          irec   = iss_q.pop_front();
          e_own  = irec[55:54];
          e_addr = irec[52:36];
          check("issue_addr", 64'(dram_address), 64'(e_addr));
          check("issue_write", 64'(dram_write), 64'(irec[53]));
          check("issue_ready", 64'(rdy), 64'(onehot(e_own)));
          if (irec[53]) begin
            check("issue_wdata", 64'(dram_wdata), 64'(irec[35:4]));
            check("issue_mask", 64'(dram_wdata_mask), 64'(irec[3:0]));
          end else if (e_own == OWN_SCREEN) begin
            check("issue_mask", 64'(dram_wdata_mask), 64'(irec[3:0]));
          end
        end
      end else if (rdy != 3'b000) begin
        check("stray_ready", 64'(rdy), 64'(0));
      end
      if (en != 3'b000) begin
        en_count++;
        if (exp_q.size() == 0) begin
          check("unexp_rdata_en", 64'(en), 64'(0));
        end else begin
          erec  = exp_q.pop_front();
          e_own = erec[33:32];
          check("rdata_owner", 64'(en), 64'(onehot(e_own)));
          case (e_own)
            OWN_SCREEN: check("screen_rdata", 64'(screen_rdata), 64'(erec[31:0]));
            OWN_CPU:    check("cpu_rdata", 64'(cpu_rdata), 64'(erec[31:0]));
            default:    check("command_rdata", 64'(command_rdata), 64'(erec[31:0]));
          endcase
          if (erec[34]) check("timeout_latency", 64'(cyc - acc_cyc), 64'(RDATA_TIMEOUT + 1));
          else          check("rdata_latency", 64'(cyc - last_dre_cyc), 64'(1));
        end
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  function automatic logic ready_of(input logic [1:0] own);
    case (own)
      OWN_SCREEN: return screen_ready;
      OWN_CPU:    return cpu_ready;
      default:    return command_ready;
    endcase
  endfunction

  task automatic req(input logic [1:0] own, input logic wr, input logic [16:0] a, input logic [7:0] d);
    int n;
    case (own)
      OWN_SCREEN: begin
        screen_address = a;
        screen_valid   = 1'b1;
      end
      OWN_CPU: begin
        cpu_address = a; cpu_write = wr; cpu_wdata = d;
        cpu_valid   = 1'b1;
      end
      default: begin
        command_address = a; command_write = wr; command_wdata = d;
        command_valid   = 1'b1;
      end
    endcase
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready_of(own) && n < 2000);
    check("ready_seen", 64'(ready_of(own)), 64'(1));
    @(posedge clk);
    #1;
    // Drop valid and scramble fields; the latched transaction must not care.
    case (own)
      OWN_SCREEN: begin
        screen_valid = 1'b0; screen_address = 17'($urandom);
      end
      OWN_CPU: begin
        cpu_valid = 1'b0; cpu_address = 17'($urandom); cpu_wdata = 8'($urandom);
        cpu_write = 1'($urandom);
      end
      default: begin
        command_valid = 1'b0; command_address = 17'($urandom);
        command_wdata = 8'($urandom); command_write = 1'($urandom);
      end
    endcase
    @(negedge clk);
    check("ready_pulse_width", 64'(ready_of(own)), 64'(0));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((iss_q.size() != 0 || exp_q.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain", 64'(iss_q.size() + exp_q.size()), 64'(0));
    repeat (2) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, 64'(debug_state), 64'(0));
    check({tag, "_dram"}, 64'({dram_valid, dram_write, dram_address, dram_wdata_mask}), 64'(0));
    check({tag, "_wdata"}, 64'(dram_wdata), 64'(0));
    check({tag, "_pulses"}, 64'({screen_ready, cpu_ready, command_ready,
                                 screen_rdata_en, cpu_rdata_en, command_rdata_en}), 64'(0));
    check({tag, "_bytes"}, 64'({cpu_rdata, command_rdata}), 64'(0));
    check({tag, "_screen_rdata"}, 64'(screen_rdata), 64'(0));
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    int base;
    logic [1:0]  own;
    logic        wr;
    logic [16:0] a;
    logic [7:0]  d;

    reset = 1'b1;
    screen_valid = 1'b0; screen_address = '0;
    cpu_valid = 1'b0; cpu_write = 1'b0; cpu_address = '0; cpu_wdata = '0;
    command_valid = 1'b0; command_write = 1'b0; command_address = '0; command_wdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_all_zero("reset");

    // CPU byte write to lane 3
    base = en_count;
    push_txn(OWN_CPU, 1'b1, 17'h00003, 8'h5A, 1'b0, 1'b0);
    req(OWN_CPU, 1'b1, 17'h00003, 8'h5A);
    drain();
    check("write_no_rdata_en", 64'(en_count - base), 64'(0));

    // CPU byte read from lane 2
    push_txn(OWN_CPU, 1'b0, 17'h00002, 8'h00, 1'b1, 1'b0);
    req(OWN_CPU, 1'b0, 17'h00002, 8'h00);
    drain();
    check("cpu_read_lane2", 64'(cpu_rdata), 64'(8'h22));

    // All three at once: screen, cpu, command
    push_txn(OWN_SCREEN, 1'b0, 17'h00100, 8'h00, 1'b1, 1'b0);
    push_txn(OWN_CPU,    1'b0, 17'h00105, 8'h00, 1'b1, 1'b0);
    push_txn(OWN_CMD,    1'b0, 17'h0020B, 8'h00, 1'b1, 1'b0);
    fork
      req(OWN_SCREEN, 1'b0, 17'h00100, 8'h00);
      req(OWN_CPU,    1'b0, 17'h00105, 8'h00);
      req(OWN_CMD,    1'b0, 17'h0020B, 8'h00);
    join
    drain();

    // CPU keeps asking: command wins after exactly four CPU grants
    for (int i = 0; i < 4; i++)
      push_txn(OWN_CPU, 1'b1, 17'h00300 + 17'(i), 8'h10 + 8'(i), 1'b0, 1'b0);
    push_txn(OWN_CMD, 1'b1, 17'h00400, 8'hC3, 1'b0, 1'b0);
    push_txn(OWN_CPU, 1'b1, 17'h00304, 8'h14, 1'b0, 1'b0);
    fork
      begin
        for (int i = 0; i < 5; i++)
          req(OWN_CPU, 1'b1, 17'h00300 + 17'(i), 8'h10 + 8'(i));
      end
      req(OWN_CMD, 1'b1, 17'h00400, 8'hC3);
    join
    drain();

    // Read that never returns: all-ones after the timeout
    no_resp = 1'b1;
    push_txn(OWN_CPU, 1'b0, 17'h00011, 8'h00, 1'b1, 1'b1);
    req(OWN_CPU, 1'b0, 17'h00011, 8'h00);
    drain();
    check("timeout_data", 64'(cpu_rdata), 64'(8'hFF));
    no_resp = 1'b0;

    // Reset while waiting for read data, then a late return
    no_resp = 1'b1;
    push_txn(OWN_CPU, 1'b0, 17'h00005, 8'h00, 1'b0, 1'b0);
    req(OWN_CPU, 1'b0, 17'h00005, 8'h00);
    check("pre_reset_wait", 64'(debug_state), 64'(2));
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    base = en_count;
    inject_dre = 1'b1;
    repeat (6) @(negedge clk);
    check("late_rdata_ignored", 64'(en_count - base), 64'(0));
    check("late_state_idle", 64'(debug_state), 64'(0));
    no_resp = 1'b0;

    // Random single transactions from any requester
    for (int i = 0; i < 12; i++) begin
      own = 2'($urandom_range(1, 3));
      wr  = (own == OWN_SCREEN) ? 1'b0 : 1'($urandom_range(0, 1));
      a   = 17'($urandom);
      d   = 8'($urandom);
      push_txn(own, wr, a, d, 1'b1, 1'b0);
      req(own, wr, a, d);
      drain();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog got=%0d exp=0", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
